// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: iomem-mapped transmit FIFO that drains into the UART transmitter.
// Register 0 (DATA) pushes a byte, register 1 (STATUS) reports full/empty/overflow/level.
// Build option UART_TX_FIFO_BLOCKING_EN: a DATA write on full stalls the bus instead of
// being dropped, and the overflow flag is never set.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_addr,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic        fifo_empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LevelFull = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LevelOne  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne    = DEPTH_LOG2'(1);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_overflow;
  logic                  r_ready;
  logic [31:0]           r_rdata;
  logic                  r_empty;

  logic [DEPTH_LOG2:0]   w_level_d;
  logic [1:0]            w_sel;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_req;
  logic                  w_data_wr;
  logic                  w_stall;
  logic                  w_push;
  logic                  w_ack;
  logic                  w_ovf_set;
  logic                  w_ovf_clr;
  logic [7:0]            w_level8;
  logic [31:0]           w_status;
  logic [31:0]           w_rdata_sel;
  logic                  w_unused;

  assign w_sel     = iomem_addr[3:2];
  assign w_full    = (r_level == LevelFull);
  // Valid is gated by ready so the transmitter never captures a byte it did not ask for.
  assign w_pop     = tx_data_ready & ~r_empty;
  assign w_req     = iomem_valid & ~r_ready;
  assign w_data_wr = w_req & iomem_wstrb[0] & (w_sel == 2'd0);

`ifdef UART_TX_FIFO_BLOCKING_EN
  // A pop in the same cycle frees the slot, so the push may proceed on that edge.
  assign w_stall   = w_data_wr & w_full & ~w_pop;
  assign w_push    = w_data_wr & ~w_stall;
  assign w_ovf_set = 1'b0;
`else
  // Full is judged before any same-cycle pop: the byte is dropped and flagged.
  assign w_stall   = 1'b0;
  assign w_push    = w_data_wr & ~w_full;
  assign w_ovf_set = w_data_wr & w_full;
`endif

  assign w_ack     = w_req & ~w_stall;
  assign w_ovf_clr = w_ack & iomem_wstrb[0] & (w_sel == 2'd1) & iomem_wdata[2];
  assign w_level8  = 8'(r_level);
  assign w_status  = {16'h0000, w_level8, 5'b00000, r_overflow, r_empty, w_full};
  assign w_unused  = ^{iomem_addr[1:0], iomem_wstrb[3:1], iomem_wdata[31:8]};

  assign iomem_ready   = r_ready;
  assign iomem_rdata   = r_rdata;
  assign tx_data       = r_mem[r_rd_ptr];
  assign tx_data_valid = w_pop;
  assign fifo_empty    = r_empty;

  // Read-data select: only STATUS returns a non-zero value.
  always_comb begin
    w_rdata_sel = 32'h0;
    if (w_sel == 2'd1) begin
      w_rdata_sel = w_status;
    end
  end

  // Next-state occupancy; push and pop together leave the level unchanged.
  always_comb begin
    w_level_d = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_d = r_level + LevelOne;
      2'b01:   w_level_d = r_level - LevelOne;
      default: w_level_d = r_level;
    endcase
  end

  // Control state: pointers, level, sticky overflow, bus acknowledge and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_ready    <= 1'b0;
      r_rdata    <= 32'h0;
      r_empty    <= 1'b1;
    end else begin
      r_ready <= w_ack;
      if (w_ack) begin
        r_rdata <= w_rdata_sel;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      r_level <= w_level_d;
      r_empty <= (w_level_d == '0);
      // Set wins over a same-cycle clear.
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage array; contents need no reset since the level qualifies every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= iomem_wdata[7:0];
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus a random mix, checked
// against a queue-based model of the FIFO and a transmitter model on the sink side.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_addr = 4'h0;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready = 1'b0;
  logic        fifo_empty;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes accepted but not yet sent, plus the sticky overflow flag.
  logic [7:0] exp_q[$];
  bit         m_ovf = 1'b0;

  // Transmitter model controls.
  bit sink_en = 1'b0;
  int busy = 1;
  int hold = 0;
  int n_pops = 0;
  bit prev_valid = 1'b0;
  int cyc = 0;
  int last_pop_cyc = -10;
  int last_ack_cyc = -20;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .iomem_valid   (iomem_valid),
    .iomem_ready   (iomem_ready),
    .iomem_addr    (iomem_addr),
    .iomem_wstrb   (iomem_wstrb),
    .iomem_wdata   (iomem_wdata),
    .iomem_rdata   (iomem_rdata),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .fifo_empty    (fifo_empty)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_model();
    int lvl;
    lvl = exp_q.size();
    return {16'h0000, 8'(lvl), 5'b00000, m_ovf, (lvl == 0), (lvl == 16)};
  endfunction

  // Transmitter: ready idles at sink_en, drops for 'busy' cycles after each capture.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (hold > 0) begin
        hold--;
        tx_data_ready = 1'b0;
      end else begin
        tx_data_ready = sink_en;
      end
      #1;
      if (rst_n) begin
        if (tx_data_valid) begin
          check("valid_needs_ready", {31'h0, tx_data_ready}, 32'h1);
          check("valid_pulse", {31'h0, prev_valid}, 32'h0);
          if (exp_q.size() == 0) check("pop_has_entry", exp_q.size(), 32'h1);
          else check("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
          n_pops++;
          last_pop_cyc = cyc;
          hold = busy;
        end
        prev_valid = tx_data_valid;
      end
    end
  end

  // One bus transaction; expectations come from the model state just before the accept edge.
  task automatic bus_xfer(input logic [3:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input string tag,
                          output logic [31:0] rd);
    logic [31:0] exp_rdata;
    bit stall_exp;
    bit late_push;
    int lat;
    @(posedge clk); #1;
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    exp_rdata = 32'h0;
    stall_exp = 1'b0;
    late_push = 1'b0;
    if (addr[3:2] == 2'd1) exp_rdata = status_model();
    if (wstrb[0] && addr[3:2] == 2'd0) begin
      if (exp_q.size() < 16) exp_q.push_back(wdata[7:0]);
`ifdef UART_TX_FIFO_BLOCKING_EN
      else begin
        stall_exp = 1'b1;
        late_push = 1'b1;
      end
`else
      else m_ovf = 1'b1;
`endif
    end
    if (wstrb[0] && addr[3:2] == 2'd1 && wdata[2]) m_ovf = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!iomem_ready && lat < 300);
    last_ack_cyc = cyc;
    check({tag, "_ack"}, {31'h0, iomem_ready}, 32'h1);
    if (!stall_exp) check({tag, "_lat"}, lat, 32'h1);
    check({tag, "_rdata"}, iomem_rdata, exp_rdata);
    rd = iomem_rdata;
    if (late_push) exp_q.push_back(wdata[7:0]);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    @(posedge clk); #1;
    check({tag, "_once"}, {31'h0, iomem_ready}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    iomem_valid = 1'b0;
    sink_en = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    hold = 0;
    n_pops = 0;
    prev_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_ready", {31'h0, iomem_ready}, 32'h0);
    check("rst_rdata", iomem_rdata, 32'h0);
    check("rst_empty", {31'h0, fifo_empty}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && n_pops < n; i++) @(posedge clk);
    check({tag, "_pops"}, n_pops, n);
  endtask

  logic [31:0] rd;
  int r;

  initial begin
    do_reset();

    // Reset while holding 5 bytes and a request in flight.
    for (int i = 0; i < 5; i++) bus_xfer(4'h0, 4'h1, 32'h60 + i, "pre_rst", rd);
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = 4'h0; iomem_wstrb = 4'h1; iomem_wdata = 32'h99;
    #2 rst_n = 1'b0;
    sink_en = 1'b1;
    #1;
    check("midrst_ready", {31'h0, iomem_ready}, 32'h0);
    check("midrst_empty", {31'h0, fifo_empty}, 32'h1);
    repeat (3) @(posedge clk);
    #2;
    check("midrst_valid", {31'h0, tx_data_valid}, 32'h0);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    exp_q.delete(); m_ovf = 1'b0; n_pops = 0;
    @(negedge clk);
    sink_en = 1'b0;
    rst_n = 1'b1;
    bus_xfer(4'h4, 4'h0, 32'h0, "rst_status", rd);
    check("rst_status_val", rd, 32'h2);

    // Ordered drain against a 115200-baud transmitter at 50 MHz (434 cycles per bit).
    do_reset();
    busy = 4340;
    @(negedge clk) sink_en = 1'b1;
    bus_xfer(4'h0, 4'h1, 32'h41, "drain_w", rd);
    bus_xfer(4'h0, 4'h1, 32'h42, "drain_w", rd);
    bus_xfer(4'h0, 4'h1, 32'h43, "drain_w", rd);
    wait_pops(3, 20000, "drain");
    @(posedge clk); #1;
    check("drain_empty", {31'h0, fifo_empty}, 32'h1);
    check("drain_model", exp_q.size(), 32'h0);

    // Ready held low: nothing may be offered until the transmitter asks.
    do_reset();
    busy = 3;
    bus_xfer(4'h0, 4'h1, 32'h11, "gate_w", rd);
    bus_xfer(4'h0, 4'h1, 32'h22, "gate_w", rd);
    repeat (10) @(posedge clk);
    #2;
    check("gate_valid_low", {31'h0, tx_data_valid}, 32'h0);
    check("gate_no_pop", n_pops, 32'h0);
    @(negedge clk) sink_en = 1'b1;
    wait_pops(2, 100, "gate");
    repeat (20) @(posedge clk);
    check("gate_no_dup", n_pops, 32'h2);

`ifndef UART_TX_FIFO_BLOCKING_EN
    // Overflow: the 17th byte is dropped and flagged.
    do_reset();
    for (int i = 0; i < 17; i++) bus_xfer(4'h0, 4'h1, i, "ovf_w", rd);
    bus_xfer(4'h4, 4'h0, 32'h0, "ovf_stat", rd);
    check("ovf_status_val", rd, 32'h1005);
    bus_xfer(4'h4, 4'h1, 32'h4, "ovf_clr", rd);
    bus_xfer(4'h4, 4'h0, 32'h0, "ovf_stat2", rd);
    check("ovf_cleared_val", rd, 32'h1001);
    busy = 2;
    @(negedge clk) sink_en = 1'b1;
    wait_pops(16, 200, "ovf");
    repeat (20) @(posedge clk);
    check("ovf_no_extra", n_pops, 32'd16);
`else
    // Blocking: the 17th write waits for the first pop and is acknowledged on that edge.
    do_reset();
    for (int i = 0; i < 16; i++) bus_xfer(4'h0, 4'h1, i, "blk_w", rd);
    busy = 50;
    fork
      bus_xfer(4'h0, 4'h1, 32'h10, "blk_17", rd);
      begin
        repeat (20) begin
          @(posedge clk); #2;
          check("blk_hold", {31'h0, iomem_ready}, 32'h0);
        end
        @(negedge clk) sink_en = 1'b1;
        for (int i = 0; i < 100 && n_pops < 1; i++) @(negedge clk);
        sink_en = 1'b0;
      end
    join
    check("blk_one_pop", n_pops, 32'h1);
    check("blk_ack_on_pop", last_ack_cyc, last_pop_cyc + 1);
    bus_xfer(4'h4, 4'h0, 32'h0, "blk_stat", rd);
    check("blk_status_val", rd, 32'h1001);
    busy = 2;
    @(negedge clk) sink_en = 1'b1;
    wait_pops(17, 300, "blk");
`endif

    // Push acknowledged on the same edge as a pop with one byte held.
    do_reset();
    busy = 50;
    bus_xfer(4'h0, 4'h1, 32'hA5, "cc_first", rd);
    @(negedge clk) sink_en = 1'b1;
    bus_xfer(4'h0, 4'h1, 32'h5A, "cc_wr", rd);
    check("cc_same_edge", last_ack_cyc, last_pop_cyc + 1);
    @(negedge clk) sink_en = 1'b0;
    bus_xfer(4'h4, 4'h0, 32'h0, "cc_stat", rd);
    check("cc_level1", rd, 32'h100);
    @(negedge clk) sink_en = 1'b1;
    wait_pops(2, 200, "cc");

    // Random mix of pushes, status reads/clears and unused registers.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
`ifdef UART_TX_FIFO_BLOCKING_EN
        sink_en = 1'b1;
`else
        sink_en = bit'($urandom_range(0, 1));
`endif
        busy = $urandom_range(1, 6);
      end
      r = $urandom_range(0, 9);
      if (r < 6)
        bus_xfer({2'd0, 2'($urandom)}, 4'($urandom_range(0, 15)), $urandom, "rnd_data", rd);
      else if (r < 8)
        bus_xfer({2'd1, 2'($urandom)}, 4'h0, $urandom, "rnd_stat", rd);
      else if (r == 8)
        bus_xfer({2'd1, 2'($urandom)}, 4'($urandom_range(1, 15)), $urandom, "rnd_clr", rd);
      else
        bus_xfer({2'($urandom_range(2, 3)), 2'($urandom)}, 4'($urandom_range(0, 15)),
                 $urandom, "rnd_misc", rd);
    end
    busy = 1;
    @(negedge clk) sink_en = 1'b1;
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    check("rnd_drained", exp_q.size(), 32'h0);
    check("rnd_empty", {31'h0, fifo_empty}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
